// File: rtl/stack_sequencer_if.sv
// Bundles the request, data-memory and response handshakes of stack_sequencer.
// The sequencer connects through the slave modport; the core/memory side uses master.
interface stack_sequencer_if #(
   parameter int ADDR_W = 32
);
   // Handshakes: a request is taken on a rising edge where req_valid && req_ready;
   // a memory access is in flight while mem_en is high and completes on a rising edge
   // with mem_ack high; a response is consumed on a rising edge where
   // resp_valid && resp_ready. All payloads hold steady while their valid is pending.
   logic              req_valid;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_data;
   logic              req_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_rdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [ADDR_W-1:0] resp_data;
   logic              resp_err;

   modport slave (
      input  req_valid, req_op, req_data, mem_ack, mem_rdata, resp_ready,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             resp_valid, resp_data, resp_err
   );

   modport master (
      output req_valid, req_op, req_data, mem_ack, mem_rdata, resp_ready,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/stack_sequencer.sv
// PUSH/POP/CALL/RET sequencer that owns SP and drives a handshaked data-memory port.
// Define SP_BOUNDS_CHECK_EN to abort overflowing/underflowing ops instead of wrapping SP.
module stack_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(1023),
   parameter logic [ADDR_W-1:0] SP_LIMIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   stack_sequencer_if.slave  bus,
   output logic [ADDR_W-1:0] sp,
   output logic [3:0]        dbg   // {sp at limit, sp at empty, state}
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MEM  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [2:0] OP_PUSH = 3'b001;
   localparam logic [2:0] OP_POP  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;

   logic [1:0] state;
   logic       op_legal;
   logic       op_write;
   logic       at_limit;
   logic       at_empty;
   logic       bound_err;
   logic       req_err;

   assign op_legal = (bus.req_op == OP_PUSH) || (bus.req_op == OP_POP) ||
                     (bus.req_op == OP_CALL) || (bus.req_op == OP_RET);
   assign op_write = (bus.req_op == OP_PUSH) || (bus.req_op == OP_CALL);
   assign at_limit = (sp == SP_LIMIT);
   assign at_empty = (sp == SP_RESET);

`ifdef SP_BOUNDS_CHECK_EN
   assign bound_err = op_write ? at_limit : at_empty;
`else
   assign bound_err = 1'b0;
`endif

   assign req_err       = !op_legal || bound_err;
   assign bus.req_ready = (state == S_IDLE);
   assign dbg           = {at_limit, at_empty, state};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         sp             <= SP_RESET;
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  if (req_err) begin
                     state          <= S_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                  end else begin
                     // The op and its data live on in mem_we/mem_wdata from here on.
                     state         <= S_MEM;
                     bus.mem_en    <= 1'b1;
                     bus.mem_we    <= op_write;
                     bus.mem_addr  <= op_write ? sp - 1'b1 : sp;
                     bus.mem_wdata <= op_write ? bus.req_data : '0;
                  end
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  state          <= S_RESP;
                  bus.mem_en     <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  if (bus.mem_we) begin
                     sp <= sp - 1'b1;
                  end else begin
                     sp            <= sp + 1'b1;
                     bus.resp_data <= bus.mem_rdata;
                  end
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  state          <= S_IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.resp_err   <= 1'b0;
                  bus.resp_data  <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed boundary cases plus random ops
// checked every cycle against a stack model built from SP arithmetic and a memory map.
module tb_stack_sequencer;
   localparam int W = 32;
   localparam logic [W-1:0] SP_RST = 32'd1023;
   localparam logic [W-1:0] SP_LIM = 32'd0;
`ifdef SP_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] sp;
   logic [3:0]   dbg;

   always #5 clk = ~clk;

   stack_sequencer_if #(.ADDR_W(W)) bus ();

   stack_sequencer #(.ADDR_W(W), .SP_RESET(SP_RST), .SP_LIMIT(SP_LIM)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .sp(sp),
      .dbg(dbg)
   );

   // ---------------- model state ----------------
   int           checks   = 0;
   int           failures = 0;
   int           phase    = -1;     // expected activity this cycle: 0 idle, 1 mem, 2 resp, -1 none
   logic [W-1:0] m_sp;
   logic [W-1:0] m_mem [bit [W-1:0]];  // what the model believes is on the stack
   logic [W-1:0] ram   [bit [W-1:0]];  // backing store the DUT actually accesses
   logic [W-1:0] exp_q [$];            // expected resp_data of the op in flight
   logic         e_we, e_err;
   logic [W-1:0] e_addr, e_wdata;
   logic [W-1:0] last_addr, last_resp;
   logic         last_err;
   int           mem_cycles;

   function automatic logic [W-1:0] fillv(input logic [W-1:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst && phase >= 0) begin
         chk1("req_ready", bus.req_ready, phase == 0);
         chk1("mem_en", bus.mem_en, phase == 1);
         chk1("resp_valid", bus.resp_valid, phase == 2);
         chk("sp", sp, m_sp);
         chk1("dbg_full", dbg[3], m_sp == SP_LIM);
         chk1("dbg_empty", dbg[2], m_sp == SP_RST);
         if (bus.mem_en) mem_cycles++;
         if (phase == 1) begin
            chk1("mem_we", bus.mem_we, e_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
            last_addr = bus.mem_addr;
         end
         if (phase == 2) begin
            chk1("resp_err", bus.resp_err, e_err);
            if (exp_q.size() == 0) chk("resp_queue_empty", 32'd0, 32'd1);
            else chk("resp_data", bus.resp_data, exp_q[0]);
            last_resp = bus.resp_data;
            last_err  = bus.resp_err;
         end else begin
            chk("resp_data_cleared", bus.resp_data, '0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge with the DUT idle; returns in the same position.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] data,
                        input int ack_dly, input int rdy_dly);
      bit legal, push, err;
      logic [W-1:0] rv;
      legal = (op >= 3'd1) && (op <= 3'd4);
      push  = (op == 3'd1) || (op == 3'd3);
      err   = !legal || (BC && push && m_sp == SP_LIM) || (BC && !push && m_sp == SP_RST);
      if (err || push) rv = '0;
      else rv = m_mem.exists(m_sp) ? m_mem[m_sp] : fillv(m_sp);
      e_we    = push;
      e_addr  = push ? m_sp - 32'd1 : m_sp;
      e_wdata = data;
      e_err   = err;
      exp_q.push_back(rv);
      mem_cycles = 0;

      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = data;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'($urandom);
      bus.req_data  = $urandom;
      if (!err) begin
         phase = 1;
         repeat (ack_dly) begin
            bus.resp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : fillv(bus.mem_addr);
         if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
         if (push) begin
            m_mem[e_addr] = data;
            m_sp = m_sp - 32'd1;
         end else begin
            m_sp = m_sp + 32'd1;
         end
      end
      phase = 2;
      bus.resp_ready = 1'b0;
      repeat (rdy_dly) begin
         bus.mem_ack   = 1'($urandom_range(0, 1));   // stray acks outside MEM
         bus.mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      bus.mem_ack    = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      void'(exp_q.pop_front());
      phase = 0;
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] fill_last;
   int           r;
   logic [2:0]   rop;

   initial begin
      rst = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = 3'd0;
      bus.req_data   = '0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
      bus.resp_ready = 1'b0;
      m_sp = SP_RST;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sp", sp, 32'd1023);
      chk1("rst_req_ready", bus.req_ready, 1'b1);
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, '0);
      chk("rst_mem_wdata", bus.mem_wdata, '0);
      chk1("rst_resp_valid", bus.resp_valid, 1'b0);
      chk1("rst_resp_err", bus.resp_err, 1'b0);
      chk("rst_resp_data", bus.resp_data, '0);
      rst = 1'b0;
      phase = 0;

      // PUSH 0xA5, ack on first MEM cycle
      do_op(3'b001, 32'hA5, 0, 0);
      chk("lit_push_addr", last_addr, 32'd1022);
      chk("lit_push_sp", sp, 32'd1022);
      chk("lit_model_sp", m_sp, 32'd1022);
      chk("lit_push_mem_cycles", 32'(mem_cycles), 32'd1);

      // POP with ack delayed three cycles
      do_op(3'b010, 32'h0, 3, 0);
      chk("lit_pop_mem_cycles", 32'(mem_cycles), 32'd4);
      chk("lit_pop_addr", last_addr, 32'd1022);
      chk("lit_pop_data", last_resp, 32'hA5);
      chk("lit_pop_sp", sp, 32'd1023);

      // POP on empty stack, response held for five cycles
      do_op(3'b010, 32'h0, 0, 5);
      chk("lit_uflow_sp", sp, BC ? 32'd1023 : 32'd1024);
      chk1("lit_uflow_err", last_err, BC);
      chk("lit_uflow_mem_cycles", 32'(mem_cycles), BC ? 32'd0 : 32'd1);

      // Illegal opcode
      do_op(3'b111, 32'h1234, 0, 1);
      chk1("lit_illegal_err", last_err, 1'b1);
      chk("lit_illegal_mem_cycles", 32'(mem_cycles), 32'd0);

      // Reset asserted in the middle of a memory access
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b011;
      bus.req_data  = 32'hCAFE;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      phase = -1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk1("rst_mid_mem_en", bus.mem_en, 1'b0);
      chk("rst_mid_sp", sp, 32'd1023);
      chk("rst_mid_state", 32'(dbg[1:0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_sp = SP_RST;
      exp_q.delete();
      phase = 0;
      chk1("rst_mid_req_ready", bus.req_ready, 1'b1);

      // Fill the stack down to SP_LIMIT, then one more CALL and a RET
      fill_last = '0;
      for (int i = 0; i < 1023; i++) begin
         fill_last = $urandom;
         do_op((i % 2 == 0) ? 3'b001 : 3'b011, fill_last, 0, 0);
      end
      chk("lit_full_sp", sp, 32'd0);
      do_op(3'b011, 32'hDEAD_BEEF, 0, 0);
      chk1("lit_oflow_err", last_err, BC);
      chk("lit_oflow_sp", sp, BC ? 32'd0 : 32'hFFFF_FFFF);
      do_op(3'b100, 32'h0, 1, 0);
      chk("lit_ret_data", last_resp, BC ? fill_last : 32'hDEAD_BEEF);

      // Random traffic around the full boundary
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) rop = (r < 2) ? 3'b001 : 3'b011;
         else if (r < 8) rop = (r < 6) ? 3'b010 : 3'b100;
         else begin
            case ($urandom_range(0, 3))
               0: rop = 3'b000;
               1: rop = 3'b101;
               2: rop = 3'b110;
               default: rop = 3'b111;
            endcase
         end
         do_op(rop, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      phase = -1;
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Sequences PUSH, POP, CALL and RET stack operations for the processor core. Owns the stack pointer register and drives the data-memory port with a request/acknowledge handshake. Returns popped data (register value or return address) to the writeback stage. Sits between the decode/execute control and data memory, and replaces direct per-cycle SP arithmetic with a handshaked, bounds-checked multi-cycle sequence.

## Interface
- ADDR_W, 32, width of SP, memory address and data
- SP_RESET, 1023, SP value after reset; also the empty-stack value
- SP_LIMIT, 0, lowest address the stack may occupy; the full-stack value

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  operation request
- req_op  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET; all other codes are illegal
- req_data  in  ADDR_W  PUSH: R[Rs]; CALL: NPC; ignored for POP/RET
- req_ready  out  1  high only in IDLE
- mem_en  out  1  memory access request, held until mem_ack
- mem_we  out  1  1 = write (PUSH/CALL), 0 = read (POP/RET)
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  ADDR_W  write data
- mem_ack  in  1  access complete; read data valid in the same cycle
- mem_rdata  in  ADDR_W  read data
- resp_valid  out  1  operation complete
- resp_ready  in  1  consumer accepts response
- resp_data  out  ADDR_W  popped value (POP/RET); 0 for PUSH/CALL/errors
- resp_err  out  1  operation aborted (illegal op, overflow, underflow)
- sp  out  ADDR_W  current stack pointer

## Operation
- States: IDLE, MEM, RESP.
- IDLE: req_ready=1. On req_valid, classify the op:
  - Illegal op: go to RESP with resp_err=1. SP is unchanged.
  - PUSH/CALL with sp==SP_LIMIT (overflow): go to RESP with resp_err=1.
  - POP/RET with sp==SP_RESET (underflow): go to RESP with resp_err=1.
  - Otherwise go to MEM.
    - PUSH/CALL: mem_addr=sp-1, mem_we=1, mem_wdata=req_data.
    - POP/RET: mem_addr=sp, mem_we=0.
- MEM: mem_en=1. mem_addr, mem_we and mem_wdata are stable until mem_ack.
  - On mem_ack, update SP: PUSH/CALL sp<=sp-1; POP/RET sp<=sp+1.
  - POP/RET also capture resp_data<=mem_rdata.
  - Go to RESP.
- RESP: resp_valid=1, with resp_data and resp_err stable. On resp_ready go to IDLE and clear resp_valid, resp_err and resp_data.
- Stack grows downward. The empty stack is sp==SP_RESET. Valid entries occupy [sp, SP_RESET-1].
- SP arithmetic is modulo 2^ADDR_W.
- The request is sampled only in IDLE. req_op and req_data are registered on acceptance; later changes are ignored.

## Timing
- Reset (asynchronous, effective immediately, including mid-operation):
  - state=IDLE, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - resp_valid=0, resp_data=0, resp_err=0, sp=SP_RESET.
  - Any in-flight access is abandoned and SP is not updated.
- Request accepted at edge T: mem_en is high from cycle T+1.
- mem_ack in cycle T+1:
  - sp and resp_data update at the end of that cycle.
  - resp_valid is high in cycle T+2.
  - Minimum latency from request to response is 2 cycles.
- Error path: resp_valid is high in cycle T+1; mem_en never asserts.
- Back-to-back ops: after resp_ready in RESP, IDLE is re-entered next cycle. The minimum issue interval is 3 cycles.
- If mem_ack arrives while not in MEM, it is ignored.
- sp is registered and changes only on the mem_ack edge or on reset.

## Configuration
- SP_BOUNDS_CHECK_EN defined: overflow and underflow are detected as described above. The op is aborted with resp_err=1, with no memory access and no SP change.
- SP_BOUNDS_CHECK_EN undefined: no bounds checks. PUSH at sp==SP_LIMIT and POP at sp==SP_RESET proceed normally, and SP wraps modulo 2^ADDR_W. resp_err is asserted only for illegal opcodes.

## Test plan
- Reset, then PUSH req_data=0xA5 with mem_ack on the first MEM cycle:
  - mem_addr=1022, mem_we=1, mem_wdata=0xA5.
  - sp=1022; resp_valid 2 cycles after accept with resp_err=0.
- After that PUSH, POP with mem_rdata=0xA5 and mem_ack delayed 3 cycles:
  - mem_en held 4 cycles with mem_addr=1022.
  - resp_data=0xA5, sp=1023.
- POP immediately after reset, SP_BOUNDS_CHECK_EN defined:
  - resp_valid next cycle with resp_err=1; mem_en stays 0; sp stays 1023.
- With SP_BOUNDS_CHECK_EN undefined: sp becomes 1024 after the POP.
- SP_RESET=2, SP_LIMIT=0: CALL, CALL, CALL.
  - Third CALL returns resp_err=1 and sp=0.
  - RET then returns the second CALL's NPC, with sp=1.
- req_op=3'b111: resp_err=1, no mem_en.
- Assert rst mid-MEM: mem_en drops immediately; sp=1023 and state is IDLE after release.
- Hold resp_ready=0 for 5 cycles: resp_valid and resp_data stay stable and req_ready stays 0.
